// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: label type codes,
// the legal-type test and the sequencer state encoding.
package mem_access_arbiter_pkg;

    localparam int LBTYPE_W = 8;

    typedef logic [LBTYPE_W-1:0] lbtype_t;

    // Label type codes; anything not listed here is treated as illegal.
    localparam lbtype_t LBTYPE_UNDEFINED = 8'h00;
    localparam lbtype_t LBTYPE_VPTR      = 8'h01;
    localparam lbtype_t LBTYPE_SINT1     = 8'h02;
    localparam lbtype_t LBTYPE_SINT2     = 8'h03;
    localparam lbtype_t LBTYPE_SINT4     = 8'h04;
    localparam lbtype_t LBTYPE_SINT8     = 8'h05;
    localparam lbtype_t LBTYPE_SINT16    = 8'h06;
    localparam lbtype_t LBTYPE_SINT32    = 8'h07;
    localparam lbtype_t LBTYPE_UINT1     = 8'h08;
    localparam lbtype_t LBTYPE_UINT2     = 8'h09;
    localparam lbtype_t LBTYPE_UINT4     = 8'h0a;
    localparam lbtype_t LBTYPE_UINT8     = 8'h0b;
    localparam lbtype_t LBTYPE_UINT16    = 8'h0c;
    localparam lbtype_t LBTYPE_UINT32    = 8'h0d;
    localparam lbtype_t LBTYPE_CODE      = 8'h0e;

    typedef enum logic [2:0] {
        MA_IDLE   = 3'd0,
        MA_LOOKUP = 3'd1,
        MA_CHECK  = 3'd2,
        MA_MEM    = 3'd3,
        MA_RESP   = 3'd4
    } ma_state_e;

    // UNDEFINED is deliberately absent: an undefined label can never be accessed.
    function automatic logic is_legal_type(input lbtype_t t);
        logic legal;
        legal = 1'b0;
        case (t)
            LBTYPE_VPTR,
            LBTYPE_SINT1, LBTYPE_SINT2, LBTYPE_SINT4,
            LBTYPE_SINT8, LBTYPE_SINT16, LBTYPE_SINT32,
            LBTYPE_UINT1, LBTYPE_UINT2, LBTYPE_UINT4,
            LBTYPE_UINT8, LBTYPE_UINT16, LBTYPE_UINT32,
            LBTYPE_CODE: legal = 1'b1;
            default:     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Core-side bundle of the two requester ports plus the shared response
// signals. The core pipeline is the master; the arbiter is the slave.
interface mem_access_arbiter_if #(
    parameter int LBID_W = 12,
    parameter int ADDR_W = 16,
    parameter int TYPE_W = 8,
    parameter int DATA_W = 32
) ();

    logic              req0;
    logic              req1;
    logic [LBID_W-1:0] lbid0;
    logic [LBID_W-1:0] lbid1;
    logic [ADDR_W-1:0] ofs0;
    logic [ADDR_W-1:0] ofs1;
    logic [TYPE_W-1:0] rtype0;
    logic [TYPE_W-1:0] rtype1;
    logic              we0;
    logic              we1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              fault;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0, req1, lbid0, lbid1, ofs0, ofs1,
               rtype0, rtype1, we0, we1, wdata0, wdata1,
        input  ack0, ack1, fault, rdata, busy
    );

    modport slave (
        input  req0, req1, lbid0, lbid1, ofs0, ofs1,
               rtype0, rtype1, we0, we1, wdata0, wdata1,
        output ack0, ack1, fault, rdata, busy
    );

endinterface

// File: rtl/mem_access_arbiter_rr.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// pointer decides.
module mem_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic gnt_idx,
    output logic gnt_vld
);

    // Pure combinational choice; the pointer only matters when both ask.
    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = (req0 && req1) ? rr_ptr : req1;
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Memory access arbiter: grants one of two requesters, looks the label up,
// checks type and bounds, then performs the data-memory access or faults.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int LBID_W = 12,
    parameter int ADDR_W = 16,
    parameter int TYPE_W = 8,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_arbiter_if.slave core,
    output logic [LBID_W-1:0]  lbt_lbid,
    input  logic [TYPE_W-1:0]  lbt_typ,
    input  logic [ADDR_W-1:0]  lbt_base,
    input  logic [ADDR_W-1:0]  lbt_count,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    ma_state_e         state;
    logic              rr_ptr;
    logic              port_q;
    logic              gnt_idx;
    logic              gnt_vld;

    logic [LBID_W-1:0] sel_lbid;
    logic [ADDR_W-1:0] sel_ofs;
    logic [TYPE_W-1:0] sel_rtype;
    logic              sel_we;
    logic [DATA_W-1:0] sel_wdata;

    logic [ADDR_W-1:0] ofs_q;
    logic [TYPE_W-1:0] rtype_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic              ack0_q;
    logic              ack1_q;
    logic              fault_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] addr;
    logic              type_ok;
    logic              bound_ok;
    logic              access_ok;
    logic              mem_fire;

    mem_arb_rr u_rr (
        .req0    (core.req0),
        .req1    (core.req1),
        .rr_ptr  (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Steer the winning requester's fields toward the capture registers.
    always_comb begin
        sel_lbid  = gnt_idx ? core.lbid1  : core.lbid0;
        sel_ofs   = gnt_idx ? core.ofs1   : core.ofs0;
        sel_rtype = gnt_idx ? core.rtype1 : core.rtype0;
        sel_we    = gnt_idx ? core.we1    : core.we0;
        sel_wdata = gnt_idx ? core.wdata1 : core.wdata0;
    end

    // Address formation and access legality; the address wraps silently and
    // a zero-count label can never satisfy the bounds test.
    always_comb begin
        addr      = lbt_base + ofs_q;
        type_ok   = is_legal_type(rtype_q) && (rtype_q == lbt_typ);
        bound_ok  = ofs_q < lbt_count;
        access_ok = type_ok && bound_ok;
        mem_fire  = (state == MA_CHECK) && access_ok && !reset;
    end

    // The label table answers only in CHECK, so the memory request is driven
    // straight out of that cycle; reset suppresses it so an abandoned write
    // never lands.
    assign mem_we    = mem_fire && we_q;
    assign mem_addr  = mem_fire ? addr : '0;
    assign mem_wdata = mem_fire ? wdata_q : '0;

    assign core.ack0  = ack0_q;
    assign core.ack1  = ack1_q;
    assign core.fault = fault_q;
    assign core.rdata = rdata_q;
    assign core.busy  = (state != MA_IDLE);

    // Sequencer: grant, lookup, check, optional memory cycle, response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= MA_IDLE;
            rr_ptr   <= 1'b0;
            port_q   <= 1'b0;
            ofs_q    <= '0;
            rtype_q  <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            lbt_lbid <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                MA_IDLE: begin
                    if (gnt_vld) begin
                        port_q   <= gnt_idx;
                        lbt_lbid <= sel_lbid;
                        ofs_q    <= sel_ofs;
                        rtype_q  <= sel_rtype;
                        we_q     <= sel_we;
                        wdata_q  <= sel_wdata;
                        state    <= MA_LOOKUP;
                    end
                end
                MA_LOOKUP: begin
                    state <= MA_CHECK;
                end
                MA_CHECK: begin
                    if (access_ok) begin
                        state <= MA_MEM;
                    end else begin
                        ack0_q  <= !port_q;
                        ack1_q  <= port_q;
                        fault_q <= 1'b1;
                        state   <= MA_RESP;
                    end
                end
                MA_MEM: begin
                    if (!we_q) begin
                        rdata_q <= mem_rdata;
                    end
                    ack0_q <= !port_q;
                    ack1_q <= port_q;
                    state  <= MA_RESP;
                end
                MA_RESP: begin
                    rr_ptr <= !port_q;
                    state  <= MA_IDLE;
                end
                default: begin
                    state <= MA_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences every memory access through label-table lookup, address/bounds check and data-memory access.
- Shares that single path between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Sits between the core pipeline and the label table / data memory.
- Converts a (label id, offset, requested type) triple into a checked memory access, or into a fault.

Parameters:
- LBID_W, 12, label id width
- ADDR_W, 16, offset/base/count/address width
- TYPE_W, 8, label type width
- DATA_W, 32, memory data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req0 / req1  in  1  access request, held until matching ack
- lbid0 / lbid1  in  LBID_W  label id
- ofs0 / ofs1  in  ADDR_W  element offset within label
- rtype0 / rtype1  in  TYPE_W  requested label type
- we0 / we1  in  1  1=write, 0=read
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- fault  out  1  valid with ack; 1=access rejected
- rdata  out  DATA_W  read data, valid with ack on a non-faulting read
- busy  out  1  FSM not in IDLE
- lbt_lbid  out  LBID_W  label table read index (1-cycle synchronous read)
- lbt_typ  in  TYPE_W  label table type
- lbt_base  in  ADDR_W  label table base
- lbt_count  in  ADDR_W  label table element count
- mem_addr  out  ADDR_W  data memory address
- mem_we  out  1  data memory write strobe
- mem_wdata  out  DATA_W  data memory write data
- mem_rdata  in  DATA_W  data memory read data (1-cycle latency)

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rr pointer=port 0.
  - ack0, ack1, fault, busy, mem_we = 0; rdata, mem_addr, mem_wdata, lbt_lbid = 0.
  - Reset mid-operation abandons the access: no ack, no further mem_we. A requester still holding req is re-arbitrated after reset.
- FSM: IDLE -> LOOKUP -> CHECK -> {MEM -> RESP | RESP} -> IDLE.
- IDLE:
  - If any req is high, grant: if only one is high, take it; if both, take the port the rr pointer names.
  - Latch lbid, ofs, rtype, we, wdata and the granted port id; drive lbt_lbid=lbid; go to LOOKUP.
  - Request fields changing after grant are ignored.
- LOOKUP: wait one cycle for the label table outputs; go to CHECK.
- CHECK: compute the following.
  - addr = lbt_base + ofs, modulo 2^ADDR_W; wrap-around is not a fault.
  - ok requires all three conditions:
    - rtype is in the legal type set (LBTYPE_UNDEFINED and unlisted codes are illegal);
    - rtype == lbt_typ;
    - ofs < lbt_count, unsigned.
  - count=0 always faults.
  - If ok: drive mem_addr=addr, mem_wdata=latched wdata, mem_we=latched we for exactly this one cycle; go to MEM.
  - If not ok: mem_we stays 0 and memory is never touched; set the fault flag; go to RESP.
- MEM: capture mem_rdata into rdata when a read; rdata holds its previous value on a write. Go to RESP.
- RESP:
  - Pulse ack of the granted port for one cycle; fault is driven in the same cycle.
  - fault is 0 on all other cycles.
  - Flip the rr pointer to the other port; go to IDLE.
- Latency: grant in cycle T gives ack at T+4 (good access) or T+3 (fault).
  - Back-to-back grant is possible in the cycle after RESP, so throughput is one access per 5 cycles.
- Requesters must drop req in the cycle after their ack. A req still high then is treated as a new request.
- Simultaneous requests alternate strictly. A lone requester is always granted regardless of the rr pointer.

Decomposition:
- Shared package:
  - LBTYPE_* constants (UNDEFINED, VPTR, SINT/UINT 1/2/4/8/16/32, CODE);
  - the is-legal-type function;
  - FSM state encoding (MA_IDLE, MA_LOOKUP, MA_CHECK, MA_MEM, MA_RESP).
- One sub-module is natural: mem_arb_rr, the 2-way round-robin picker (inputs req0, req1, rr pointer; output grant index and grant valid).

Test Plan:
- Label 3 = {typ=LBTYPE_CODE, base=0xff00, count=0x00ff}. Port 0 read: lbid=3, ofs=4, rtype=CODE, memory[0xff04]=0x12345678.
  -> mem_addr=0xff04 at T+2; ack0 at T+4; fault=0; rdata=0x12345678.
- Same label, port 1 write: ofs=3, count=4, wdata=0xdeadbeef.
  -> one-cycle mem_we at T+2 with addr 0xff03; ack1 at T+4; fault=0.
- Port 0, ofs=4, count=4 (out of bounds); and separately rtype=VPTR vs CODE (type mismatch); and rtype=UNDEFINED.
  -> ack0 at T+3; fault=1; mem_we never asserted.
- req0 and req1 both held high continuously for 4 accesses.
  -> grants alternate 0,1,0,1; each ack exactly one cycle; busy drops only for the single IDLE cycle between accesses.
- Port 1 write in flight; reset asserted in CHECK.
  -> no mem_we, no ack1; all outputs 0 next cycle. req1 still high is re-granted from IDLE and completes normally.
- base=0xfff0, ofs=0x20, count=0x40.
  -> addr wraps to 0x0010; fault=0.
